// File: rtl/alu_serial_exec.sv
// alu_serial_exec: execute-stage ALU; logic/arith/compare in one cycle, shifts bit-serial (BARREL_SHIFT_EN: one-cycle barrel shifts).
// Latency 1, or shamt+1 for serial shifts. One op in flight: in_ready only in IDLE, result held in DONE until out_ready.
module alu_serial_exec #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  busy
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1100;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_NE  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } sh_t;

    state_t                state_q, state_d;
    sh_t                   sh_q, sh_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [SHAMT_W-1:0]    cnt_q, cnt_d;

    logic                  accept;
    logic                  is_shift;
    logic [SHAMT_W-1:0]    shamt;
    sh_t                   sh_kind;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0] shift_step;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign ALUResult = result_q;
    assign Zero      = ~|result_q;

    assign accept   = in_valid && in_ready;
    assign shamt    = SrcB[SHAMT_W-1:0];
    assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);

    always_comb begin
        sh_kind = SH_SLL;
        case (Operation)
            OP_SRL:  sh_kind = SH_SRL;
            OP_SRA:  sh_kind = SH_SRA;
            default: sh_kind = SH_SLL;
        endcase
    end

    // Single-cycle result; in the serial build a shift only reaches here when shamt is 0.
    always_comb begin
        alu_res = '0;
        case (Operation)
            OP_AND: alu_res = SrcA & SrcB;
            OP_OR:  alu_res = SrcA | SrcB;
            OP_ADD: alu_res = SrcA + SrcB;
            OP_SUB: alu_res = SrcA - SrcB;
            OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_EQ:  alu_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
            OP_NE:  alu_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
`ifdef BARREL_SHIFT_EN
            OP_SLL: alu_res = SrcA << shamt;
            OP_SRL: alu_res = SrcA >> shamt;
            OP_SRA: alu_res = $signed(SrcA) >>> shamt;
`else
            OP_SLL: alu_res = SrcA;
            OP_SRL: alu_res = SrcA;
            OP_SRA: alu_res = SrcA;
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        shift_step = result_q;
        case (sh_q)
            SH_SLL:  shift_step = {result_q[DATA_WIDTH-2:0], 1'b0};
            SH_SRL:  shift_step = {1'b0, result_q[DATA_WIDTH-1:1]};
            SH_SRA:  shift_step = {result_q[DATA_WIDTH-1], result_q[DATA_WIDTH-1:1]};
            default: shift_step = result_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
`ifdef BARREL_SHIFT_EN
                        result_d = alu_res;
                        state_d  = ST_DONE;
`else
                        if (is_shift && (shamt != '0)) begin
                            result_d = SrcA;
                            cnt_d    = shamt;
                            sh_d     = sh_kind;
                            state_d  = ST_SHIFT;
                        end else begin
                            result_d = alu_res;
                            state_d  = ST_DONE;
                        end
`endif
                    end
                end
                ST_SHIFT: begin
                    result_d = shift_step;
                    cnt_d    = cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sh_q     <= SH_SLL;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    // A presented result must not change or vanish until it is taken.
    a_hold_result: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(ALUResult)));

    a_ready_excl_busy: assert property (@(posedge clk) disable iff (reset)
        !(in_ready && busy));

endmodule

// File: tb/tb_alu_serial_exec.sv
// Self-checking bench for alu_serial_exec: scoreboard queue of expected results, one task per scenario.
module tb_alu_serial_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    alu_serial_exec #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a - b;
            4'b0100: return a << b[4:0];
            4'b0101: return a >> b[4:0];
            4'b0111: return $signed(a) >>> b[4:0];
            4'b1100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: return (a == b) ? 32'd1 : 32'd0;
            4'b1001: return (a != b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_latency(input logic [3:0] op, input logic [31:0] b);
`ifdef BARREL_SHIFT_EN
        return (op == 4'hF && b == 32'd0) ? 1 : 1;
`else
        if ((op == 4'b0100 || op == 4'b0101 || op == 4'b0111) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
`endif
    endfunction

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() > 0) return exp_q.pop_front();
        return 32'hxxxx_xxxx;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        exp_q.push_back(model(op, a, b));
        step();
        in_valid  = 1'b0;
        Operation = 4'($urandom);
        SrcA      = $urandom;
        SrcB      = $urandom;
    endtask

    // Returns with out_valid observed (lat = cycles after accept), or lat = -1 on timeout.
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cnt);
        issue(op, a, b);
        lat      = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_cnt++;
            step();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (ALUResult !== 32'd0) begin errors++; $display("FAIL reset_result got=%h want=0", ALUResult); end
        checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b want=1", Zero); end
        #10 reset = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got in_ready=%b busy=%b want 1/0", in_ready, busy); end
    endtask

    task automatic test_add();
        int lat, bc;
        logic [31:0] e;
        run(4'b0010, 32'h5, 32'h3, lat, bc);
        e = pop_exp();
        checks++; if (ALUResult !== e || ALUResult !== 32'h8) begin errors++; $display("FAIL add_result got=%h want=%h", ALUResult, e); end
        checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL add_zero got=%b want=0", Zero); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d want=1", lat); end
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_drain got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_logic_ops();
        logic [3:0]  ops [11];
        logic [31:0] as  [11];
        logic [31:0] bs  [11];
        int lat, bc;
        logic [31:0] e;
        ops = '{4'b0011, 4'b1000, 4'b1001, 4'b1100, 4'b1100, 4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1111, 4'b0011};
        as  = '{32'h1234, 32'h1234, 32'h1234, 32'hFFFFFFFF, 32'h1, 32'hF0F0_1234, 32'hF0F0_0000, 32'hFFFFFFFF, 32'hDEAD_BEEF, 32'h1, 32'h0};
        bs  = '{32'h1234, 32'h1234, 32'h1234, 32'h1, 32'hFFFFFFFF, 32'h0FF0_FF00, 32'h0000_0F0F, 32'h1, 32'h1, 32'h1, 32'h1};
        for (int i = 0; i < 11; i++) begin
            run(ops[i], as[i], bs[i], lat, bc);
            e = pop_exp();
            checks++; if (ALUResult !== e) begin errors++; $display("FAIL logic_result[%0d] op=%b got=%h want=%h", i, ops[i], ALUResult, e); end
            checks++; if (Zero !== (e == 32'd0)) begin errors++; $display("FAIL logic_zero[%0d] got=%b want=%b", i, Zero, (e == 32'd0)); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL logic_latency[%0d] got=%0d want=1", i, lat); end
            step();
        end
    endtask

    task automatic test_shifts();
        logic [3:0]  ops [7];
        logic [31:0] as  [7];
        logic [31:0] bs  [7];
        int lat, bc, el;
        logic [31:0] e;
        ops = '{4'b0111, 4'b0100, 4'b0111, 4'b0101, 4'b0100, 4'b0111, 4'b0100};
        as  = '{32'h8000_0000, 32'h1, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'h7000_0000, 32'hFFFF_FFFF};
        bs  = '{32'd4, 32'd0, 32'd31, 32'd31, 32'hFFFF_FFE3, 32'd8, 32'd31};
        for (int i = 0; i < 7; i++) begin
            run(ops[i], as[i], bs[i], lat, bc);
            e  = pop_exp();
            el = exp_latency(ops[i], bs[i]);
            checks++; if (ALUResult !== e) begin errors++; $display("FAIL shift_result[%0d] got=%h want=%h", i, ALUResult, e); end
            checks++; if (lat !== el) begin errors++; $display("FAIL shift_latency[%0d] got=%0d want=%0d", i, lat, el); end
            checks++; if (bc !== el - 1) begin errors++; $display("FAIL shift_busy_cycles[%0d] got=%0d want=%0d", i, bc, el - 1); end
            step();
        end
    endtask

    task automatic test_backpressure();
        int lat, bc;
        logic [31:0] e;
        out_ready = 1'b0;
        run(4'b0010, 32'h10, 32'h20, lat, bc);
        e = pop_exp();
        in_valid = 1'b1; Operation = 4'b0010; SrcA = 32'h1; SrcB = 32'h1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || ALUResult !== e) begin errors++; $display("FAIL bp_hold[%0d] got valid=%b res=%h want 1/%h", i, out_valid, ALUResult, e); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain got valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
    endtask

    task automatic test_flush();
        int lat, bc;
        logic seen;
        // flush beats accept in the same cycle
        in_valid = 1'b1; Operation = 4'b0010; SrcA = 32'h3; SrcB = 32'h4; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_vs_accept got busy=%b in_ready=%b want 0/1", busy, in_ready); end
        // flush while a result waits in DONE
        out_ready = 1'b0;
        run(4'b0010, 32'h2, 32'h2, lat, bc);
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_done got valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        exp_q.delete();
`ifndef BARREL_SHIFT_EN
        issue(4'b0101, 32'hFFFF_FFFF, 32'd20);
        seen = 1'b0;
        for (int c = 1; c < 7; c++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_busy got busy=%b in_ready=%b want 1/0", busy, in_ready); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_shift got busy=%b in_ready=%b valid=%b want 0/1/0", busy, in_ready, out_valid); end
        for (int c = 0; c < 30; c++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_output got out_valid seen=%b want 0", seen); end
        exp_q.delete();
`endif
    endtask

    task automatic test_async_reset();
        int lat, bc;
        logic [31:0] e;
        issue(4'b0101, 32'hFFFF_FFFF, 32'd20);
        step();
        step();
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL areset_ctrl got busy=%b in_ready=%b valid=%b want 0/1/0", busy, in_ready, out_valid); end
        checks++; if (ALUResult !== 32'd0 || Zero !== 1'b1) begin errors++; $display("FAIL areset_result got res=%h zero=%b want 0/1", ALUResult, Zero); end
        #2 reset = 1'b0;
        exp_q.delete();
        step();
        run(4'b0010, 32'h7, 32'h0, lat, bc);
        e = pop_exp();
        checks++; if (ALUResult !== e || lat !== 1) begin errors++; $display("FAIL areset_recover got res=%h lat=%0d want %h/1", ALUResult, lat, e); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [11];
        logic [3:0] op;
        logic [31:0] a, b, e;
        int lat, bc, el;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'hC, 4'h8, 4'h9, 4'hE};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 10)];
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 0) ? a : $urandom;
            run(op, a, b, lat, bc);
            e  = pop_exp();
            el = exp_latency(op, b);
            checks++; if (ALUResult !== e || Zero !== (e == 32'd0)) begin errors++; $display("FAIL b2b_result[%0d] op=%h a=%h b=%h got=%h/%b want=%h", i, op, a, b, ALUResult, Zero, e); end
            checks++; if (lat !== el) begin errors++; $display("FAIL b2b_latency[%0d] got=%0d want=%0d", i, lat, el); end
            step();
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d] got in_ready=%b valid=%b want 1/0", i, in_ready, out_valid); end
        end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Operation = 4'h0;
        SrcA      = 32'h0;
        SrcB      = 32'h0;
        test_reset();
        test_add();
        test_logic_ops();
        test_shifts();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
